mac_array_ctrl: RTL
===================

MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

Interface
REQ-001 SHALL have parameters: row, 8, number of mac_row instances; col, 8, tiles per row; aw, 11, SRAM address width; lw, 10, execute-length width.
REQ-002 SHALL have ports: clk  input  1  clock (all logic on posedge).
REQ-003 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: start  input  1  run request, sampled only in IDLE.
REQ-005 SHALL have ports: w_base  input  aw  first weight address, captured at accepted start.
REQ-006 SHALL have ports: a_base  input  aw  first activation address, captured at accepted start.
REQ-007 SHALL have ports: exec_len  input  lw  activation vectors to stream, captured at accepted start.
REQ-008 SHALL have ports: sram_cen  output  1  SRAM chip enable, active-low.
REQ-009 SHALL have ports: sram_addr  output  aw  SRAM read address.
REQ-010 SHALL have ports: inst_w  output  2*row  per-row instruction, bits [2r+1:2r] for row r; bit1 execute, bit0 kernel load.
REQ-011 SHALL have ports: busy  output  1  high from the first cycle after an accepted start through the done cycle.
REQ-012 SHALL have ports: done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, KLOAD, KGAP, EXEC, DRAIN, DONE.
REQ-014 SHALL go IDLE->KLOAD on start=1; start outside IDLE is ignored.
REQ-015 KLOAD SHALL last col cycles: sram_cen=0, sram_addr=w_base+k for k=0..col-1.
REQ-016 KGAP SHALL last row cycles: sram_cen=1, row-0 instruction 00.
REQ-017 EXEC SHALL last exec_len cycles: sram_cen=0, sram_addr=a_base+k; exec_len=0 goes KGAP->DRAIN directly.
REQ-018 DRAIN SHALL last row+col-1 cycles with sram_cen=1; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 Row-0 instruction SHALL be registered one cycle after the matching read (1-cycle SRAM latency): 01 for each KLOAD read, 10 for each EXEC read, else 00.
REQ-020 Row r instruction SHALL equal row-0 instruction delayed r cycles via an instruction shift chain (systolic skew).
REQ-021 Address arithmetic SHALL be modulo 2^aw; wrap-around SHALL NOT be flagged.
REQ-022 In IDLE, sram_cen SHALL be 1 and sram_addr SHALL hold its last value.
REQ-023 Start SHALL be accepted on the cycle after DONE; back-to-back runs SHALL introduce no extra idle cycle beyond the IDLE cycle.

Reset
REQ-024 While reset=1 at a clock edge: state=IDLE, sram_cen=1, sram_addr=0, inst_w=0 (entire skew chain), busy=0, done=0, counters=0.
REQ-025 Reset mid-run SHALL abort immediately with no done pulse; start in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 Macro MAC_ARRAY_CTRL_STALL_EN SHALL, when defined, add input port stall (1 bit): in KLOAD/EXEC with stall=1, sram_cen=1, address and counters frozen, row-0 instruction 00 next cycle; skew chain keeps shifting; other states ignore stall.
REQ-027 Without MAC_ARRAY_CTRL_STALL_EN, port stall SHALL be absent and behaviour SHALL equal stall tied to 0.

Verification (row=col=8, start accepted at cycle T0)
REQ-028 w_base=0, a_base=16, exec_len=4 -> sram_cen=0 T1-T8 addr 0..7 and T17-T20 addr 16..19; row-0 inst 01 T2-T9, 10 T18-T21; done at T36 only; busy T1-T36.
REQ-029 Same run -> row-7 inst 01 T9-T16, 10 T25-T28; all rows 00 elsewhere.
REQ-030 exec_len=0 -> no EXEC reads; DRAIN T17-T31; done at T32.
REQ-031 a_base=2046, exec_len=4 -> EXEC addresses 2046, 2047, 0, 1.
REQ-032 reset=1 at T12 -> from T13 state IDLE, inst_w=0, busy=0, no done; start at T13 is accepted and the run restarts normally.
REQ-033 With MAC_ARRAY_CTRL_STALL_EN, stall=1 at T3-T4 -> addr 2 held, cen=1 T3-T4, row-0 inst 00 T4-T5, KLOAD ends T10, done at T38.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// Sequencer for a row x col systolic MAC array: kernel load, gap, execute, drain, done.
// Optional define MAC_ARRAY_CTRL_STALL_EN adds a stall input that pauses SRAM reads.
module mac_array_ctrl #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int aw  = 11,
  parameter int lw  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef MAC_ARRAY_CTRL_STALL_EN
  input  logic              stall,
`endif
  input  logic [aw-1:0]     w_base,
  input  logic [aw-1:0]     a_base,
  input  logic [lw-1:0]     exec_len,
  output logic              sram_cen,
  output logic [aw-1:0]     sram_addr,
  output logic [2*row-1:0]  inst_w,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] KLOAD = 3'd1;
  localparam logic [2:0] KGAP  = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  // wide enough for exec_len as well as the row+col-1 drain count
  localparam int cw = lw + $clog2(row + col + 1);
  localparam logic [cw-1:0] ONE        = cw'(1);
  localparam logic [cw-1:0] KLOAD_LAST = cw'(col - 1);
  localparam logic [cw-1:0] KGAP_LAST  = cw'(row - 1);
  localparam logic [cw-1:0] DRAIN_LAST = cw'(row + col - 2);

  logic [2:0]    state;
  logic [cw-1:0] cnt;
  logic [aw-1:0] a_base_q;
  logic [lw-1:0] len_q;
  logic [1:0]    inst_q [row];
  logic          stall_i;
  logic          kload_rd;
  logic          exec_rd;
  logic [cw-1:0] exec_last;

`ifdef MAC_ARRAY_CTRL_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign kload_rd  = (state == KLOAD) && !stall_i;
  assign exec_rd   = (state == EXEC) && !stall_i;
  assign exec_last = cw'(len_q) - ONE;

  assign sram_cen = !(kload_rd || exec_rd);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_addr <= '0;
      a_base_q  <= '0;
      len_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= KLOAD;
            cnt       <= '0;
            sram_addr <= w_base;
            a_base_q  <= a_base;
            len_q     <= exec_len;
          end
        end
        KLOAD: begin
          if (!stall_i) begin
            if (cnt == KLOAD_LAST) begin
              state <= KGAP;
              cnt   <= '0;
            end else begin
              cnt       <= cnt + ONE;
              sram_addr <= sram_addr + aw'(1);
            end
          end
        end
        KGAP: begin
          if (cnt == KGAP_LAST) begin
            cnt <= '0;
            if (len_q == '0) begin
              state <= DRAIN;
            end else begin
              state     <= EXEC;
              sram_addr <= a_base_q;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        EXEC: begin
          if (!stall_i) begin
            if (cnt == exec_last) begin
              state <= DRAIN;
              cnt   <= '0;
            end else begin
              cnt       <= cnt + ONE;
              sram_addr <= sram_addr + aw'(1);
            end
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Row 0 sees the instruction one cycle after its read; each further row one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < row; r++) inst_q[r] <= 2'b00;
    end else begin
      inst_q[0] <= {exec_rd, kload_rd};
      for (int r = 1; r < row; r++) inst_q[r] <= inst_q[r-1];
    end
  end

  always_comb begin
    inst_w = '0;
    for (int r = 0; r < row; r++) inst_w[2*r +: 2] = inst_q[r];
  end

endmodule
